scope_capture_buffer: RTL and testbench

Acquisition stage directly upstream of the waveform colour/pixel stages. It accepts a 10-bit ADC sample stream and stores samples in a DEPTH-entry circular buffer. It detects a level-crossing trigger, fills the post-trigger window, then freezes the frame. The display reads the frozen frame by screen column; each column read returns a sample in display order.

---
 rtl/scope_pkg.sv | 14 +
 rtl/scope_capture_buffer_if.sv | 39 +++
 rtl/scope_edge_detect.sv | 40 ++++
 rtl/scope_capture_buffer.sv | 174 +++++++++++++++++
 tb/tb_scope_capture_buffer.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/scope_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | scope_pkg : shared types and constants for the scope capture slice   |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package scope_pkg;
  localparam int SCREEN_W = 640;
  localparam int SAMPLE_W = 10;

  typedef enum logic [2:0] {IDLE, PRETRIG, ARMED, POST, DONE} capture_state_t;
  typedef enum logic [1:0] {NORMAL, AUTO, SINGLE} trig_mode_t;
endpackage
`default_nettype wire

// File: rtl/scope_capture_buffer_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | scope_capture_buffer_if : sample, trigger-control and readout bundle |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
interface scope_capture_buffer_if
  import scope_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W
);
  logic              i_sample_valid;
  logic [DATA_W-1:0] i_sample;
  logic [DATA_W-1:0] i_level;
  logic              i_edge;
  logic [1:0]        i_mode;
  logic [9:0]        i_pretrig;
  logic              i_arm;
  logic              i_release;
  logic [9:0]        i_rd_x;
  logic [DATA_W-1:0] o_rd_data;
  logic              o_frame_valid;
  logic              o_triggered;
  logic [9:0]        o_trigger_x;
  logic              o_busy;

  modport master (
    output i_sample_valid, i_sample, i_level, i_edge, i_mode, i_pretrig,
    output i_arm, i_release, i_rd_x,
    input  o_rd_data, o_frame_valid, o_triggered, o_trigger_x, o_busy
  );

  modport slave (
    input  i_sample_valid, i_sample, i_level, i_edge, i_mode, i_pretrig,
    input  i_arm, i_release, i_rd_x,
    output o_rd_data, o_frame_valid, o_triggered, o_trigger_x, o_busy
  );
endinterface
`default_nettype wire

// File: rtl/scope_edge_detect.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | scope_edge_detect : previous-sample register and level-crossing test |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module scope_edge_detect #(
  parameter int DATA_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_update,
  input  logic [DATA_W-1:0] i_sample,
  input  logic [DATA_W-1:0] i_level,
  input  logic              i_edge,
  output logic              o_hit
);
  logic [DATA_W-1:0] r_prev;
  logic              r_prev_valid;
  logic              w_rise;
  logic              w_fall;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
    end else if (i_clear) begin
      r_prev_valid <= 1'b0;
    end else if (i_update) begin
      r_prev       <= i_sample;
      r_prev_valid <= 1'b1;
    end
  end

  assign w_rise = (r_prev <  i_level) && (i_sample >= i_level);
  assign w_fall = (r_prev >= i_level) && (i_sample <  i_level);
  assign o_hit  = r_prev_valid && (i_edge ? w_fall : w_rise);
endmodule
`default_nettype wire

// File: rtl/scope_capture_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | scope_capture_buffer : triggered circular capture with column readout|
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module scope_capture_buffer
  import scope_pkg::*;
#(
  parameter int DATA_W       = SAMPLE_W,
  parameter int DEPTH        = SCREEN_W,
  parameter int AUTO_TIMEOUT = 100000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  scope_capture_buffer_if.slave bus_if
);
  localparam int              c_AW      = 10;
  localparam int              c_AW1     = c_AW + 1;
  localparam int              c_TO_W    = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [c_AW-1:0] c_LAST    = c_AW'(DEPTH - 1);
  localparam logic [c_AW:0]   c_DEPTH_X = c_AW1'(DEPTH);

  capture_state_t    r_state;
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_pre_cnt;
  logic [c_AW-1:0]   r_pre_len;
  logic [c_AW-1:0]   r_rd_base;
  logic [c_AW-1:0]   r_trigger_x;
  logic [c_AW:0]     r_post_cnt;
  logic [c_TO_W-1:0] r_to_cnt;
  logic              r_triggered;
  logic              r_frame_valid;
  logic              r_busy;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_single;
  logic              w_auto;
  logic              w_capturing;
  logic              w_valid;
  logic              w_wr_en;
  logic              w_enter;
  logic              w_hit;
  logic              w_timeout;
  logic              w_edge_clear;
  logic [c_AW-1:0]   w_pre_len_in;
  logic [c_AW:0]     w_post_len;
  logic [c_AW-1:0]   w_trig_base;
  logic [c_AW-1:0]   w_col;
  logic [c_AW:0]     w_sum;
  logic [c_AW-1:0]   w_rd_addr;

  assign w_single     = (bus_if.i_mode == SINGLE);
  assign w_auto       = (bus_if.i_mode == AUTO);
  assign w_valid      = bus_if.i_sample_valid;
  assign w_capturing  = (r_state == PRETRIG) || (r_state == ARMED) || (r_state == POST);
  assign w_wr_en      = w_valid && w_capturing;
  assign w_edge_clear = (r_state == IDLE) || (r_state == DONE);
  assign w_pre_len_in = (bus_if.i_pretrig > c_LAST) ? c_LAST : bus_if.i_pretrig;
  assign w_enter      = ((r_state == IDLE) && (!w_single || bus_if.i_arm)) ||
                        ((r_state == DONE) && bus_if.i_release && !w_single);
  assign w_timeout    = w_auto && ((r_to_cnt + c_TO_W'(1)) == c_TO_W'(AUTO_TIMEOUT));
  assign w_post_len   = c_DEPTH_X - {1'b0, r_pre_len};
  // Oldest frame column sits pre_len entries behind the trigger sample.
  assign w_trig_base  = (r_wr_ptr >= r_pre_len) ? (r_wr_ptr - r_pre_len)
                                                : (r_wr_ptr + c_AW'(DEPTH) - r_pre_len);

  scope_edge_detect #(.DATA_W(DATA_W)) u_edge (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (w_edge_clear),
    .i_update (w_wr_en),
    .i_sample (bus_if.i_sample),
    .i_level  (bus_if.i_level),
    .i_edge   (bus_if.i_edge),
    .o_hit    (w_hit)
  );

  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= bus_if.i_sample;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_wr_ptr      <= '0;
      r_pre_cnt     <= '0;
      r_pre_len     <= '0;
      r_rd_base     <= '0;
      r_trigger_x   <= '0;
      r_post_cnt    <= '0;
      r_to_cnt      <= '0;
      r_triggered   <= 1'b0;
      r_frame_valid <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + c_AW'(1);
      end
      if (w_enter) begin
        // A zero-length pre-trigger window has nothing to fill, so arm at once.
        r_pre_len     <= w_pre_len_in;
        r_pre_cnt     <= '0;
        r_post_cnt    <= '0;
        r_to_cnt      <= '0;
        r_state       <= (w_pre_len_in == '0) ? ARMED : PRETRIG;
        r_busy        <= 1'b1;
        r_frame_valid <= 1'b0;
      end else begin
        case (r_state)
          PRETRIG: begin
            if (w_valid) begin
              r_pre_cnt <= r_pre_cnt + c_AW'(1);
              if ((r_pre_cnt + c_AW'(1)) == r_pre_len) begin
                r_state <= ARMED;
              end
            end
          end
          ARMED: begin
            if (w_valid) begin
              if (w_hit || w_timeout) begin
                r_rd_base   <= w_trig_base;
                r_trigger_x <= r_pre_len;
                r_triggered <= w_hit;
                r_post_cnt  <= c_AW1'(1);
                if (w_post_len == c_AW1'(1)) begin
                  r_state       <= DONE;
                  r_busy        <= 1'b0;
                  r_frame_valid <= 1'b1;
                end else begin
                  r_state <= POST;
                end
              end else if (w_auto) begin
                r_to_cnt <= r_to_cnt + c_TO_W'(1);
              end
            end
          end
          POST: begin
            if (w_valid) begin
              r_post_cnt <= r_post_cnt + c_AW1'(1);
              if ((r_post_cnt + c_AW1'(1)) == w_post_len) begin
                r_state       <= DONE;
                r_busy        <= 1'b0;
                r_frame_valid <= 1'b1;
              end
            end
          end
          DONE: begin
            // Non-single release is taken by the entry path above.
            if (bus_if.i_release) begin
              r_state       <= IDLE;
              r_frame_valid <= 1'b0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign w_col     = (bus_if.i_rd_x > c_LAST) ? c_LAST : bus_if.i_rd_x;
  assign w_sum     = {1'b0, r_rd_base} + {1'b0, w_col};
  assign w_rd_addr = (w_sum >= c_DEPTH_X) ? c_AW'(w_sum - c_DEPTH_X) : c_AW'(w_sum);

  assign bus_if.o_rd_data     = r_mem[w_rd_addr];
  assign bus_if.o_frame_valid = r_frame_valid;
  assign bus_if.o_triggered   = r_triggered;
  assign bus_if.o_trigger_x   = r_trigger_x;
  assign bus_if.o_busy        = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_scope_capture_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_scope_capture_buffer : frame-level checks of scope_capture_buffer |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module tb_scope_capture_buffer;
  localparam int DEPTH = 640;
  localparam int TO    = 50;

  typedef struct {
    int pat;   int mode;  int level; int fall; int pre; int gap;
    int exp_tx; int exp_trg; int cx0; int cv0; int cx1; int cv1;
  } vec_t;

  logic clk;
  logic rst;
  bit   clk_run;
  int   n_cmp;
  int   n_bad;
  int   acc[$];
  vec_t vecs[9];

  scope_capture_buffer_if #(.DATA_W(10)) bus ();

  scope_capture_buffer #(.DATA_W(10), .DEPTH(DEPTH), .AUTO_TIMEOUT(TO)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .bus_if (bus.slave)
  );

  always #5 if (clk_run) clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s %s: got %0d required %0d", tag, nm, act, exp);
    end
  endtask

  function automatic int gen(input int pat, input int i);
    case (pat)
      0:       return (8 * i) % 1024;
      1:       return ((i / 20) % 2 == 0) ? 900 : 100;
      2:       return 200;
      default: return int'($urandom_range(0, 1023));
    endcase
  endfunction

  task automatic set_params(input vec_t v);
    bus.i_mode    = 2'(v.mode);
    bus.i_level   = 10'(v.level);
    bus.i_edge    = (v.fall != 0);
    bus.i_pretrig = 10'(v.pre);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic release_pulse(input string tag);
    bus.i_release = 1'b1;
    step();
    bus.i_release = 1'b0;
    check(tag, "frame_valid after release", bus.o_frame_valid, 0);
  endtask

  // Feeds samples while the DUT is capturing; every valid sample seen then is part of the record.
  task automatic run_capture(input int pat, input int gap, input int max_cyc, output bit ok);
    int v;
    acc.delete();
    bus.i_sample_valid = 1'b0;
    for (int n = 0; n < 20 && !bus.o_busy; n++) step();
    ok = 1'b0;
    for (int n = 0; n < max_cyc; n++) begin
      if (bus.o_frame_valid) begin
        ok = 1'b1;
        break;
      end
      if (int'($urandom_range(0, 99)) >= gap) begin
        v = gen(pat, acc.size());
        bus.i_sample       = 10'(v);
        bus.i_sample_valid = 1'b1;
        acc.push_back(v);
      end else begin
        bus.i_sample_valid = 1'b0;
      end
      step();
    end
    bus.i_sample_valid = 1'b0;
  endtask

  // Reference: the frame is the last DEPTH accepted samples, with the trigger at column pre_len.
  task automatic verify(input string tag, input vec_t v, input bit ok);
    int pl, t, real_hit, base, bad_x, bad_a, bad_e;
    bit hit;
    pl = (v.pre > DEPTH - 1) ? DEPTH - 1 : v.pre;
    check(tag, "capture completed", ok, 1);
    check(tag, "frame_valid", bus.o_frame_valid, 1);
    check(tag, "busy", bus.o_busy, 0);
    check(tag, "trigger_x", bus.o_trigger_x, v.exp_tx);
    t = -1;
    real_hit = 0;
    for (int i = pl; i < acc.size(); i++) begin
      hit = (i >= 1) && ((v.fall != 0) ? (acc[i-1] >= v.level && acc[i] < v.level)
                                       : (acc[i-1] <  v.level && acc[i] >= v.level));
      if (hit) begin
        t = i; real_hit = 1;
        break;
      end
      if (v.mode == 1 && (i - pl + 1) == TO) begin
        t = i;
        break;
      end
    end
    check(tag, "triggered", bus.o_triggered, (v.exp_trg < 0) ? real_hit : v.exp_trg);
    check(tag, "samples in capture", acc.size(), (t < 0) ? -1 : t + DEPTH - pl);
    if (acc.size() >= DEPTH) begin
      base  = acc.size() - DEPTH;
      bad_x = -1; bad_a = 0; bad_e = 0;
      for (int x = 0; x < DEPTH; x++) begin
        bus.i_rd_x = 10'(x);
        #1;
        if (bad_x < 0 && int'(bus.o_rd_data) != acc[base+x]) begin
          bad_x = x; bad_a = int'(bus.o_rd_data); bad_e = acc[base+x];
        end
      end
      n_cmp++;
      if (bad_x >= 0) begin
        n_bad++;
        $display("FAIL %s frame column %0d: got %0d required %0d", tag, bad_x, bad_a, bad_e);
      end
      bus.i_rd_x = 10'd700;
      #1 check(tag, "rd_x 700 clamps", bus.o_rd_data, acc[acc.size()-1]);
      bus.i_rd_x = 10'd1023;
      #1 check(tag, "rd_x 1023 clamps", bus.o_rd_data, acc[acc.size()-1]);
    end
    if (v.cx0 >= 0) begin
      bus.i_rd_x = 10'(v.cx0);
      #1 check(tag, $sformatf("column %0d", v.cx0), bus.o_rd_data, v.cv0);
    end
    if (v.cx1 >= 0) begin
      bus.i_rd_x = 10'(v.cx1);
      #1 check(tag, $sformatf("column %0d", v.cx1), bus.o_rd_data, v.cv1);
    end
    bus.i_rd_x = '0;
    step();
  endtask

  initial begin
    bit   ok;
    vec_t v;
    int   m;
    n_cmp = 0;
    n_bad = 0;
    // pat mode level fall pre gap | tx trg | col/value pairs
    vecs[0] = '{0, 0, 512, 0, 100,  0, 100, 1, 100, 512,  99, 504};
    vecs[1] = '{1, 0, 300, 1,   0,  0,   0, 1,   0, 100,   1, 100};
    vecs[2] = '{2, 1, 512, 0,  10, 20,  10, 0,   0, 200, 639, 200};
    vecs[3] = '{0, 0, 512, 0, 639,  0, 639, 1, 639, 512, 638, 504};
    vecs[4] = '{0, 3, 512, 0, 700, 25, 639, 1, 639, 512,   0, 520};
    vecs[5] = '{3, 0, 400, 1, 300, 30, 300, 1,  -1,   0,  -1,   0};
    vecs[6] = '{0, 1, 512, 1,   5,  0,   5, 0,   5, 432,   4, 424};
    vecs[7] = '{0, 1, 512, 0,   0,  0,   0, 0,   0, 392,   1, 400};
    vecs[8] = '{0, 1, 512, 0,  15,  0,  15, 1,   0, 392,  15, 512};

    clk = 1'b0; clk_run = 1'b1; rst = 1'b1;
    bus.i_sample_valid = 1'b0; bus.i_sample = '0; bus.i_arm = 1'b0;
    bus.i_release = 1'b0; bus.i_rd_x = '0;
    set_params(vecs[0]);
    repeat (3) step();
    check("reset", "frame_valid", bus.o_frame_valid, 0);
    check("reset", "busy", bus.o_busy, 0);
    check("reset", "triggered", bus.o_triggered, 0);
    check("reset", "trigger_x", bus.o_trigger_x, 0);
    rst = 1'b0;

    for (int r = 0; r < 9; r++) begin
      if (r > 0) begin
        set_params(vecs[r]);
        release_pulse($sformatf("vec%0d", r));
      end
      run_capture(vecs[r].pat, vecs[r].gap, 6000, ok);
      verify($sformatf("vec%0d", r), vecs[r], ok);
    end

    for (int k = 0; k < 6; k++) begin
      m = int'($urandom_range(0, 2));
      v.pat = 3; v.mode = (m == 2) ? 3 : m;
      v.level = int'($urandom_range(100, 900)); v.fall = int'($urandom_range(0, 1));
      v.pre = int'($urandom_range(0, 700)); v.gap = int'($urandom_range(0, 40));
      v.exp_tx = (v.pre > DEPTH - 1) ? DEPTH - 1 : v.pre; v.exp_trg = -1;
      v.cx0 = -1; v.cv0 = 0; v.cx1 = -1; v.cv1 = 0;
      set_params(v);
      release_pulse($sformatf("rand%0d", k));
      run_capture(v.pat, v.gap, 6000, ok);
      verify($sformatf("rand%0d", k), v, ok);
    end

    // Single mode: release parks in IDLE and edges are ignored until armed.
    v = vecs[0];
    v.mode = 2;
    set_params(v);
    release_pulse("single");
    for (int i = 0; i < 40; i++) begin
      bus.i_sample = 10'(gen(0, i)); bus.i_sample_valid = 1'b1;
      step();
    end
    bus.i_sample_valid = 1'b0;
    check("single idle", "busy", bus.o_busy, 0);
    check("single idle", "frame_valid", bus.o_frame_valid, 0);
    bus.i_arm = 1'b1;
    step();
    bus.i_arm = 1'b0;
    check("single arm", "busy", bus.o_busy, 1);
    run_capture(0, 10, 6000, ok);
    verify("single", v, ok);
    bus.i_release = 1'b1; bus.i_arm = 1'b1;
    step();
    bus.i_release = 1'b0; bus.i_arm = 1'b0;
    check("release+arm", "frame_valid", bus.o_frame_valid, 0);
    repeat (3) step();
    check("release+arm", "busy", bus.o_busy, 0);

    // Async reset in POST with the clock held, then a clean recapture.
    set_params(vecs[0]);
    step();
    for (int i = 0; i < 300; i++) begin
      bus.i_sample = 10'(gen(0, i)); bus.i_sample_valid = 1'b1;
      step();
    end
    bus.i_sample_valid = 1'b0;
    check("pre-reset", "busy", bus.o_busy, 1);
    check("pre-reset", "triggered", bus.o_triggered, 1);
    check("pre-reset", "trigger_x", bus.o_trigger_x, 100);
    clk_run = 1'b0;
    #20 rst = 1'b1;
    #1;
    check("async reset", "busy", bus.o_busy, 0);
    check("async reset", "triggered", bus.o_triggered, 0);
    check("async reset", "trigger_x", bus.o_trigger_x, 0);
    check("async reset", "frame_valid", bus.o_frame_valid, 0);
    #10 rst = 1'b0;
    #10 clk_run = 1'b1;
    step();
    run_capture(0, 0, 6000, ok);
    verify("after reset", vecs[0], ok);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
